adder_arbiter: RTL



---
 rtl/adder_arb_pkg.sv | 24 ++
 rtl/addera.sv | 18 +
 rtl/rr_arbiter.sv | 70 +++++++
 rtl/adder_arbiter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types for the adder arbiter.
//   operand_t  : default-width operand
//   req_idx_t  : requester index, wide enough for the largest supported NREQ (8)
//   owner_t    : lock owner (valid flag + requester index)
//   idx_inc    : requester index increment, wrapping at n-1 -> 0
package adder_arb_pkg;

  localparam int W_DEF    = 8;
  localparam int NREQ_DEF = 4;
  localparam int NREQ_MAX = 8;

  typedef logic [W_DEF-1:0] operand_t;
  typedef logic [$clog2(NREQ_MAX)-1:0] req_idx_t;

  typedef struct packed {
    logic     valid;
    req_idx_t idx;
  } owner_t;

  function automatic req_idx_t idx_inc(input req_idx_t i, input int n);
    return (int'(i) == n - 1) ? '0 : i + req_idx_t'(1);
  endfunction

endpackage

// File: rtl/addera.sv
// Combinational W-bit adder with carry in/out.
//   a, b  : operands
//   c_in  : carry-in
//   sum   : W-bit modulo sum
//   c_out : carry-out
module addera #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with lock-owner override (purely combinational).
//   req          : per-requester request
//   owner        : current lock owner
//   ptr          : round-robin priority pointer
//   gnt          : one-hot grant
//   gnt_idx      : index of the granted requester
//   gnt_any      : a grant was issued
//   gnt_cont     : the grant continues a locked chain
//   release_lock : owner is valid but no longer requesting
//   eff_ptr      : pointer actually used for this cycle's scan
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  owner_t          owner,
  input  req_idx_t        ptr,
  output logic [NREQ-1:0] gnt,
  output req_idx_t        gnt_idx,
  output logic            gnt_any,
  output logic            gnt_cont,
  output logic            release_lock,
  output req_idx_t        eff_ptr
);

  logic owner_req;

  always_comb begin
    owner_req = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(owner.idx) == i) owner_req = req[i];
    end
  end

  always_comb begin
    int j;
    gnt          = '0;
    gnt_idx      = '0;
    gnt_any      = 1'b0;
    gnt_cont     = 1'b0;
    release_lock = 1'b0;
    eff_ptr      = ptr;
    j            = 0;
    if (owner.valid && owner_req) begin
      gnt_any  = 1'b1;
      gnt_cont = 1'b1;
      gnt_idx  = owner.idx;
      for (int i = 0; i < NREQ; i++) begin
        if (int'(owner.idx) == i) gnt[i] = 1'b1;
      end
    end else begin
      // A stale owner hands priority to its neighbour before the scan.
      if (owner.valid) begin
        release_lock = 1'b1;
        eff_ptr      = idx_inc(owner.idx, NREQ);
      end
      for (int k = 0; k < NREQ; k++) begin
        j = int'(eff_ptr) + k;
        if (j >= NREQ) j = j - NREQ;
        if (!gnt_any && req[j]) begin
          gnt_any = 1'b1;
          gnt_idx = req_idx_t'(j);
          gnt[j]  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one addera among NREQ requesters. Round-robin grants; a locked
// requester keeps the grant and chains carry-out into the next add.
//   clk, rst_n : clock, asynchronous active-low reset
//   req, lock  : per-requester request and chain lock
//   op_a, op_b : per-requester operands
//   op_cin     : per-requester carry-in (ignored on chained grants)
//   gnt        : one-hot combinational grant
//   rsp_valid  : one-hot registered result strobe (one cycle after grant)
//   rsp_sum    : registered sum, held while rsp_valid=0
//   rsp_cout   : registered carry-out, held while rsp_valid=0
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ-1:0][W-1:0] op_a,
  input  logic [NREQ-1:0][W-1:0] op_b,
  input  logic [NREQ-1:0]       op_cin,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [W-1:0]          rsp_sum,
  output logic                  rsp_cout
);

  req_idx_t        ptr_q, ptr_d;
  owner_t          owner_q, owner_d;
  logic            carry_q, carry_d;

  logic [NREQ-1:0] gnt_arb;
  req_idx_t        gnt_idx;
  logic            gnt_any, gnt_cont, release_lock;
  req_idx_t        eff_ptr;

  logic [W-1:0]    add_a_p0, add_b_p0, sum_p0;
  logic            cin_p0, cout_p0, lock_p0, opcin_p0;

  logic [NREQ-1:0] vld_p1;
  logic [W-1:0]    sum_p1;
  logic            cout_p1;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req          (req),
    .owner        (owner_q),
    .ptr          (ptr_q),
    .gnt          (gnt_arb),
    .gnt_idx      (gnt_idx),
    .gnt_any      (gnt_any),
    .gnt_cont     (gnt_cont),
    .release_lock (release_lock),
    .eff_ptr      (eff_ptr)
  );

  assign gnt = rst_n ? gnt_arb : '0;

  // Stage p0: operand select from the one-hot grant, shared adder
  always_comb begin
    add_a_p0 = '0;
    add_b_p0 = '0;
    lock_p0  = 1'b0;
    opcin_p0 = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      add_a_p0 = add_a_p0 | (op_a[i] & {W{gnt_arb[i]}});
      add_b_p0 = add_b_p0 | (op_b[i] & {W{gnt_arb[i]}});
      lock_p0  = lock_p0  | (lock[i]   & gnt_arb[i]);
      opcin_p0 = opcin_p0 | (op_cin[i] & gnt_arb[i]);
    end
  end

  assign cin_p0 = gnt_cont ? carry_q : opcin_p0;

  addera #(.W(W)) u_add (
    .a     (add_a_p0),
    .b     (add_b_p0),
    .c_in  (cin_p0),
    .sum   (sum_p0),
    .c_out (cout_p0)
  );

  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    carry_d = carry_q;
    if (release_lock) begin
      owner_d = '0;
      carry_d = 1'b0;
      ptr_d   = eff_ptr;
    end
    if (gnt_any) begin
      if (lock_p0) begin
        owner_d.valid = 1'b1;
        owner_d.idx   = gnt_idx;
        carry_d       = cout_p0;
      end else begin
        owner_d = '0;
        carry_d = 1'b0;
        ptr_d   = idx_inc(gnt_idx, NREQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      owner_q <= '0;
      carry_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      carry_q <= carry_d;
    end
  end

  // Stage p1: registered response bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= '0;
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
    end else begin
      vld_p1 <= gnt_arb;
      if (gnt_any) begin
        sum_p1  <= sum_p0;
        cout_p1 <= cout_p0;
      end
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_sum   = sum_p1;
  assign rsp_cout  = cout_p1;

endmodule
